// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS phase-increment word from f_start to f_stop,
// holding each word for a programmable number of sample ticks (single, sawtooth or triangle).
module dds_sweep_ctrl #(
  parameter int unsigned FW = 24,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          tick,
  output logic [FW-1:0] freq_word,
  output logic          freq_load,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_STEP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] lo_q, lo_d;
  logic [FW-1:0] hi_q, hi_d;
  logic [FW-1:0] inc_q, inc_d;
  logic [FW-1:0] word_q, word_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          down_q, down_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [FW:0]   sum_c;
  logic [FW:0]   diff_c;
  logic [FW-1:0] up_nxt_c;
  logic [FW-1:0] dn_nxt_c;

  // One extra bit on both sides so the clamps see overflow / borrow instead of a wrapped word
  assign sum_c    = {1'b0, word_q} + {1'b0, inc_q};
  assign diff_c   = {1'b0, word_q} - {1'b0, inc_q};
  assign up_nxt_c = (sum_c >= {1'b0, hi_q}) ? hi_q : sum_c[FW-1:0];
  assign dn_nxt_c = (diff_c[FW] || (diff_c[FW-1:0] <= lo_q)) ? lo_q : diff_c[FW-1:0];

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    inc_d   = inc_q;
    word_d  = word_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    down_d  = down_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((f_step != '0) && (f_start <= f_stop)) begin
              mode_d  = mode;
              lo_d    = f_start;
              hi_d    = f_stop;
              inc_d   = f_step;
              dwell_d = (dwell == '0) ? DW'(1) : dwell;
              word_d  = f_start;
              load_d  = 1'b1;
              busy_d  = 1'b1;
              down_d  = 1'b0;
              cnt_d   = '0;
              state_d = ST_DWELL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_DWELL: begin
          if (tick) begin
            if (cnt_q == dwell_q - DW'(1)) begin
              cnt_d   = '0;
              state_d = ST_STEP;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end
        end
        ST_STEP: begin
          state_d = ST_DWELL;
          load_d  = 1'b1;
          if (!down_q) begin
            if (word_q < hi_q) begin
              word_d = up_nxt_c;
            end else if (mode_q == 2'd1) begin
              word_d = lo_q;
            end else if (mode_q == 2'd2) begin
              down_d = 1'b1;
              word_d = dn_nxt_c;
            end else begin
              state_d = ST_IDLE;
              load_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (word_q > lo_q) begin
            word_d = dn_nxt_c;
          end else begin
            down_d = 1'b0;
            word_d = up_nxt_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      inc_q   <= '0;
      word_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      inc_q   <= inc_d;
      word_q  <= word_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign freq_word = word_q;
  assign freq_load = load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios plus randomized traffic, all checked every
// cycle against a sweep-level model that works in plain integer arithmetic.
module tb_dds_sweep_ctrl;

  localparam int unsigned FW = 24;
  localparam int unsigned DW = 16;
  localparam longint FMAX = 64'd16777215;

  logic          clk;
  logic          rst, start, abort, tick;
  logic [1:0]    mode;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] freq_word;
  logic          freq_load, busy, done, cfg_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int tick_per = 10;
  int tph = 0;
  int done_cnt = 0;
  longint loads[$];

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell), .tick(tick),
    .freq_word(freq_word), .freq_load(freq_load), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sweep-level model: tracks the active word and how many ticks of the current hold have elapsed
  longint m_word, m_lo, m_hi, m_inc;
  int     m_dwell, m_ticks, m_mode;
  bit     m_busy, m_load, m_done, m_err, m_down, m_step_due;

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction
  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    m_load = 0; m_done = 0; m_err = 0;
    if (rst) begin
      m_word = 0; m_busy = 0; m_down = 0; m_ticks = 0; m_step_due = 0;
    end else if (abort) begin
      m_busy = 0; m_ticks = 0; m_step_due = 0;
    end else if (!m_busy) begin
      if (start) begin
        if (f_step != 0 && f_start <= f_stop) begin
          m_lo = f_start; m_hi = f_stop; m_inc = f_step; m_mode = mode;
          m_dwell = (dwell == 0) ? 1 : int'(dwell);
          m_word = m_lo; m_load = 1; m_busy = 1; m_down = 0; m_ticks = 0; m_step_due = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_step_due) begin
      m_step_due = 0;
      m_load = 1;
      if (!m_down && m_word < m_hi) m_word = lmin(m_word + m_inc, m_hi);
      else if (!m_down) begin
        if (m_mode == 1) m_word = m_lo;
        else if (m_mode == 2) begin m_down = 1; m_word = lmax(m_word - m_inc, m_lo); end
        else begin m_load = 0; m_busy = 0; m_done = 1; end
      end else if (m_word > m_lo) m_word = lmax(m_word - m_inc, m_lo);
      else begin m_down = 0; m_word = lmin(m_word + m_inc, m_hi); end
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == m_dwell) begin m_ticks = 0; m_step_due = 1; end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against model, log loads, then drive the next cycle's pulses
  task automatic clk1();
    logic [FW-1:0] ew;
    @(negedge clk);
    if (chk_en) begin
      ew = FW'(m_word);
      n_cmp++;
      if (freq_word !== ew || freq_load !== m_load || busy !== m_busy ||
          done !== m_done || cfg_err !== m_err) begin
        n_bad++;
        $display("FAIL cycle: got word=%0d load=%b busy=%b done=%b err=%b, expected word=%0d load=%b busy=%b done=%b err=%b (t=%0t)",
                 freq_word, freq_load, busy, done, cfg_err, ew, m_load, m_busy, m_done, m_err, $time);
      end
      if (freq_load === 1'b1) loads.push_back(longint'(freq_word));
      if (done === 1'b1) done_cnt++;
    end
    start = 1'b0;
    abort = 1'b0;
    if (tick_per > 0) begin
      tick = (tph == 0);
      tph = (tph + 1) % tick_per;
    end else begin
      tick = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic launch(input longint lo, input longint hi, input longint inc, input int dw,
                        input int md);
    clk1();
    f_start = FW'(lo); f_stop = FW'(hi); f_step = FW'(inc); dwell = DW'(dw); mode = 2'(md);
    start = 1'b1;
    clk1();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin clk1(); n++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", budget);
    end
  endtask

  task automatic wait_word(input longint w, input int budget);
    int n = 0;
    while (!(freq_load === 1'b1 && longint'(freq_word) == w) && n < budget) begin clk1(); n++; end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_word: word %0d not loaded within %0d cycles, got %0d", w, budget, freq_word);
    end
  endtask

  task automatic chk_seq(input string nm, input longint e[8], input int n, input bit exact);
    if (exact) chk({nm, "_count"}, loads.size(), n);
    else chk({nm, "_enough"}, (loads.size() >= n) ? 1 : 0, 1);
    for (int i = 0; i < n; i++)
      if (i < loads.size()) chk(nm, loads[i], e[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0; mode = 2'd0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    clk1(); clk1();
    chk_en = 1;
    rst = 1'b0;
    clk1();
    chk("reset_word", freq_word, 0);
    chk("reset_busy", busy, 0);

    // Single sweep 100..130 step 10, dwell 2
    tick_per = 10; loads.delete(); done_cnt = 0;
    launch(100, 130, 10, 2, 0);
    wait_idle(500);
    chk_seq("single", '{100, 110, 120, 130, 0, 0, 0, 0}, 4, 1);
    chk("single_done", done_cnt, 1);

    // Saturation at f_stop, dwell 0 behaves as 1
    tick_per = 3; loads.delete(); done_cnt = 0;
    launch(0, 25, 10, 0, 0);
    wait_idle(200);
    chk_seq("sat", '{0, 10, 20, 25, 0, 0, 0, 0}, 4, 1);
    chk("sat_done", done_cnt, 1);

    // Top-of-range step must clamp, not wrap
    tick_per = 2; loads.delete();
    launch(5, FMAX, FMAX - 1, 1, 0);
    wait_idle(100);
    chk_seq("nowrap", '{5, FMAX, 0, 0, 0, 0, 0, 0}, 2, 1);

    // Sawtooth and triangle repeat
    for (int md = 1; md <= 2; md++) begin
      tick_per = 3; loads.delete(); done_cnt = 0;
      launch(0, 20, 10, 1, md);
      repeat (200) clk1();
      if (md == 1) chk_seq("saw", '{0, 10, 20, 0, 10, 20, 0, 0}, 6, 0);
      else chk_seq("tri", '{0, 10, 20, 10, 0, 10, 20, 10}, 8, 0);
      chk("repeat_no_done", done_cnt, 0);
      chk("repeat_busy", busy, 1);
      abort = 1'b1;
      clk1();
      chk("repeat_abort_busy", busy, 0);
    end

    // Abort mid-dwell holds the word
    tick_per = 4; done_cnt = 0;
    launch(100, 200, 10, 5, 0);
    wait_word(110, 200);
    repeat (10) clk1();
    abort = 1'b1;
    clk1();
    chk("abort_word", freq_word, 110);
    chk("abort_busy", busy, 0);
    chk("abort_load", freq_load, 0);
    repeat (30) clk1();
    chk("abort_no_done", done_cnt, 0);

    // Same-cycle start and abort while idle
    loads.delete();
    clk1();
    f_start = 24'd0; f_stop = 24'd50; f_step = 24'd5; dwell = 16'd1; mode = 2'd0;
    start = 1'b1; abort = 1'b1;
    clk1();
    chk("startabort_busy", busy, 0);
    chk("startabort_load", loads.size(), 0);

    // Rejected configurations
    launch(10, 50, 0, 1, 0);
    chk("rej_step0_err", cfg_err, 1);
    chk("rej_step0_busy", busy, 0);
    clk1();
    chk("rej_err_onepulse", cfg_err, 0);
    launch(50, 40, 5, 1, 0);
    chk("rej_order_err", cfg_err, 1);

    // Reset mid-sweep, then a normal sweep
    tick_per = 3;
    launch(100, 200, 10, 2, 1);
    wait_word(120, 200);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk("rst_word", freq_word, 0);
    chk("rst_busy", busy, 0);
    loads.delete();
    launch(0, 20, 10, 1, 0);
    wait_idle(200);
    chk_seq("post_rst", '{0, 10, 20, 0, 0, 0, 0, 0}, 3, 1);

    // Randomized traffic; config wiggles every cycle so mid-sweep changes get exercised
    for (int c = 0; c < 20000; c++) begin
      longint lo, hi, inc;
      clk1();
      if (c % 1000 == 0) tick_per = $urandom_range(0, 5);
      lo = $urandom_range(0, 120);
      hi = $urandom_range(0, 120);
      inc = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) begin
        hi = FMAX - $urandom_range(0, 3);
        lo = hi - $urandom_range(0, 100);
        inc = ($urandom_range(0, 1) == 1) ? FMAX - 1 : longint'($urandom_range(0, 60));
      end
      f_start = FW'(lo); f_stop = FW'(hi); f_step = FW'(inc);
      dwell = DW'($urandom_range(0, 4));
      mode = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 24) == 0);
      abort = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 1999) == 0);
    end
    clk1();
    rst = 1'b0;
    repeat (5) clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
